// File: rtl/fb_pixel_writer_pkg.sv
// Shared display constants and the pixel-writer state encoding.
package fb_pixel_writer_pkg;

  localparam int FB_XRES       = 640;
  localparam int FB_YRES       = 480;
  localparam int FB_ADDR_WIDTH = 19;
  localparam int FB_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream into the frame-buffer writer: data, framing flags, handshake.
interface fb_pixel_writer_if
  import fb_pixel_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    output pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    input  pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/fb_pixel_writer_addr_gen.sv
// Raster position tracking (x, y, row base) and write-address generation.
// The row base steps by XRES per line with an adder, so no multiplier is used.
module fb_pixel_writer_addr_gen
  import fb_pixel_writer_pkg::*;
#(
  parameter int XRES       = FB_XRES,
  parameter int YRES       = FB_YRES,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,      // accepted SOF beat
  input  logic                  beat,       // accepted non-SOF beat inside a frame
  input  logic                  eol,        // end-of-line flag of the current beat
  output logic [ADDR_WIDTH-1:0] wr_addr,    // address for the current beat
  output logic                  x_full,     // line already holds XRES pixels
  output logic                  last_line   // current line is y = YRES-1
);

  // x saturates at XRES so an overlong line can be recognised until its EOL
  localparam int X_W = $clog2(XRES + 1);
  localparam int Y_W = $clog2(YRES + 1);

  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [ADDR_WIDTH-1:0] row_base_q;

  // An SOF beat always lands on address 0 whatever the counters hold
  assign wr_addr   = start ? '0 : (row_base_q + ADDR_WIDTH'(x_q));
  assign x_full    = (x_q == X_W'(XRES));
  assign last_line = (y_q == Y_W'(YRES - 1));

  // Advance the raster position on accepted beats; SOF restarts the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else if (start) begin
      if (eol) begin
        x_q        <= '0;
        y_q        <= Y_W'(1);
        row_base_q <= ADDR_WIDTH'(XRES);
      end else begin
        x_q        <= X_W'(1);
        y_q        <= '0;
        row_base_q <= '0;
      end
    end else if (beat) begin
      if (eol) begin
        x_q        <= '0;
        y_q        <= y_q + Y_W'(1);
        row_base_q <= row_base_q + ADDR_WIDTH'(XRES);
      end else if (!x_full) begin
        x_q        <= x_q + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer pixel writer: takes a framed RGB332 pixel stream and turns it
// into a registered block-RAM write port, one write per accepted pixel.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int XRES       = FB_XRES,
  parameter int YRES       = FB_YRES,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  clk_en,
  fb_pixel_writer_if.slave      pix,
  output logic                  WES,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  frame_done,
  output logic                  line_err,
  output logic                  sync_err
);

  logic [1:0]            rst_sync_q;
  logic                  rst_n;

  wr_state_e             state_q;
  wr_state_e             state_d;

  logic                  accept;
  logic                  sof_beat;
  logic                  data_beat;
  logic                  drop_beat;
  logic                  wr_now;
  logic                  done_now;

  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  x_full;
  logic                  last_line;

  logic                  wes_p1;
  logic [DATA_WIDTH-1:0] dout_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  frame_done_q;
  logic                  line_err_q;
  logic                  sync_err_q;

  // Reset asserts at once but releases only after two clock edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Beat classification; ready is held low while reset or the DONE cycle lasts
  assign pix.pix_ready = rst_n & clk_en & (state_q != ST_DONE);
  assign accept        = pix.pix_valid & pix.pix_ready;
  assign sof_beat      = accept & pix.pix_sof;
  assign data_beat     = accept & ~pix.pix_sof & (state_q == ST_WRITE);
  assign drop_beat     = data_beat & x_full;
  assign wr_now        = sof_beat | (data_beat & ~x_full);
  assign done_now      = pix.pix_eol &
                         ((sof_beat & (YRES == 1)) | (data_beat & last_line));

  fb_pixel_writer_addr_gen #(
    .XRES       (XRES),
    .YRES       (YRES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (sof_beat),
    .beat      (data_beat),
    .eol       (pix.pix_eol),
    .wr_addr   (gen_addr),
    .x_full    (x_full),
    .last_line (last_line)
  );

  // Writer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: SOF opens a frame, last-line EOL closes it, DONE lasts one enabled cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sof_beat) begin
          state_d = done_now ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (done_now) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (clk_en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- stage p1: registered block-RAM write port ----
  // Strobe follows every cycle; data and address hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wes_p1  <= 1'b0;
      dout_p1 <= '0;
      addr_p1 <= '0;
    end else begin
      wes_p1 <= wr_now;
      if (wr_now) begin
        dout_p1 <= pix.pix_data;
        addr_p1 <= gen_addr;
      end
    end
  end

  // Frame-complete flag mirrors the DONE cycle and only moves when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else if (clk_en) begin
      frame_done_q <= done_now;
    end
  end

  // Sticky errors: overlong line cleared by the next SOF, SOF-in-frame by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_err_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (sof_beat) begin
        line_err_q <= 1'b0;
      end else if (drop_beat) begin
        line_err_q <= 1'b1;
      end
      if (sof_beat && (state_q == ST_WRITE)) begin
        sync_err_q <= 1'b1;
      end
    end
  end

  assign WES        = wes_p1;
  assign dout       = dout_p1;
  assign addr       = addr_p1;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: randomized framed pixel stream against a
// raster-level reference model (address = y*XRES + x).
module tb_fb_pixel_writer;

  localparam int XR = 640;
  localparam int YR = 24;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          clk_en;
  logic          wes;
  logic [DW-1:0] dout;
  logic [AW-1:0] addr;
  logic          frame_done;
  logic          line_err;
  logic          sync_err;

  fb_pixel_writer_if #(.DATA_WIDTH(DW)) pif ();

  fb_pixel_writer #(
    .XRES       (XR),
    .YRES       (YR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .pix        (pif.slave),
    .WES        (wes),
    .dout       (dout),
    .addr       (addr),
    .frame_done (frame_done),
    .line_err   (line_err),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err;
  int n_checks;

  // reference model state
  bit          m_inframe, m_done, m_le, m_se, m_wes;
  int          mx, my, m_addr, rst_cnt;
  logic [7:0]  m_dout;

  // observations
  typedef struct { int a; int d; } wr_t;
  wr_t wlog[$];
  int  n_wes, n_fd, last_addr, max_addr, n_bad_en, phase;

  function automatic void model_reset();
    m_inframe = 0; m_done = 0; m_le = 0; m_se = 0; m_wes = 0;
    mx = 0; my = 0; m_addr = 0; m_dout = '0; rst_cnt = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit acc, input bit s,
                                     input bit e, input logic [7:0] d);
    if (rst_cnt < 2) rst_cnt++;
    m_wes = 0;
    if (en && m_done) m_done = 0;
    if (acc) begin
      if (s) begin
        if (m_inframe) m_se = 1;
        m_le = 0; m_inframe = 1; mx = 0; my = 0;
      end
      if (m_inframe) begin
        if (mx < XR) begin
          m_wes = 1; m_addr = my * XR + mx; m_dout = d; mx++;
        end else begin
          m_le = 1;
        end
        if (e) begin
          mx = 0; my++;
          if (my == YR) begin m_inframe = 0; m_done = 1; end
        end
      end
    end
  endfunction

  task automatic cyc(input bit en, input bit v, input bit s, input bit e,
                     input logic [7:0] d, output bit acc);
    bit         exp_rdy;
    logic [3:0] got_ctl, exp_ctl;
    wr_t        w;
    clk_en = en; pif.pix_valid = v; pif.pix_sof = s; pif.pix_eol = e; pif.pix_data = d;
    exp_rdy = en && !m_done && (rst_cnt >= 2);
    #1;
    n_checks++;
    if (pif.pix_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL pix_ready: got %b want %b at t=%0t", pif.pix_ready, exp_rdy, $time);
    end
    acc = v && exp_rdy;
    @(posedge clk);
    model_edge(en, acc, s, e, d);
    #1;
    got_ctl = {wes, frame_done, line_err, sync_err};
    exp_ctl = {m_wes, m_done, m_le, m_se};
    n_checks++;
    if (got_ctl !== exp_ctl) begin
      n_err++;
      $display("FAIL ctl{wes,done,lerr,serr}: got %b want %b at t=%0t", got_ctl, exp_ctl, $time);
    end
    n_checks++;
    if ({addr, dout} !== {AW'(m_addr), m_dout}) begin
      n_err++;
      $display("FAIL wr_port: got addr=%0d dout=%h want addr=%0d dout=%h at t=%0t",
               addr, dout, m_addr, m_dout, $time);
    end
    if (wes === 1'b1) begin
      w.a = int'(addr); w.d = int'(dout);
      wlog.push_back(w);
      n_wes++; last_addr = w.a;
      if (w.a > max_addr) max_addr = w.a;
      if (!en) n_bad_en++;
    end
    if (frame_done === 1'b1) n_fd++;
  endtask

  // mode 0: continuous; 1: clk_en one cycle in three; 2: random bubbles
  task automatic push(input bit s, input bit e, input logic [7:0] d, input int mode);
    bit acc, dummy, en;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 32) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), dummy);
        else                           cyc(1'b0, 1'b1, s, e, 8'($urandom), dummy);
      end
      en = (mode == 1) ? (phase % 3 == 0) : 1'b1;
      phase++;
      cyc(en, 1'b1, s, e, d, acc);
      tries++;
    end
    if (!acc) begin
      n_checks++; n_err++;
      $display("FAIL push_timeout: not accepted after %0d cycles, want accepted", tries);
    end
  endtask

  task automatic send_line(input int row, input int n, input bit sof, input int mode, input bit rnd);
    for (int i = 0; i < n; i++) begin
      push(sof && (i == 0), i == n - 1, rnd ? 8'($urandom) : 8'(row * XR + i), mode);
    end
  endtask

  task automatic idle(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, dummy);
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({pif.pix_ready, wes, frame_done, line_err, sync_err} !== 5'b0) begin
      n_err++;
      $display("FAIL %s ctl{rdy,wes,done,lerr,serr}: got %b want 00000", tag,
               {pif.pix_ready, wes, frame_done, line_err, sync_err});
    end
    n_checks++;
    if ({addr, dout} !== '0) begin
      n_err++;
      $display("FAIL %s wr_port: got addr=%0d dout=%h want 0/00", tag, addr, dout);
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1;
    pif.pix_valid = 1'b0; pif.pix_sof = 1'b0; pif.pix_eol = 1'b0; pif.pix_data = '0;
    #1 rst = 1'b0;
    #1;
    check_all_zero("reset_initial");
    pif.pix_valid = 1'b1; pif.pix_sof = 1'b1; pif.pix_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_full_frame();
    n_wes = 0; n_fd = 0; last_addr = -1; max_addr = 0;
    for (int r = 0; r < YR; r++) send_line(r, XR, r == 0, 2, 1'b0);
    idle(3);
    n_checks++;
    if (n_wes != XR * YR) begin n_err++; $display("FAIL frame_writes: got %0d want %0d", n_wes, XR * YR); end
    n_checks++;
    if (last_addr != XR * YR - 1) begin n_err++; $display("FAIL frame_last_addr: got %0d want %0d", last_addr, XR * YR - 1); end
    n_checks++;
    if (max_addr != XR * YR - 1) begin n_err++; $display("FAIL frame_max_addr: got %0d want %0d", max_addr, XR * YR - 1); end
    n_checks++;
    if (n_fd != 1) begin n_err++; $display("FAIL frame_done_cycles: got %0d want 1", n_fd); end
    n_checks++;
    if ({line_err, sync_err} !== 2'b00) begin n_err++; $display("FAIL frame_errs: got %b want 00", {line_err, sync_err}); end
  endtask

  task automatic test_long_line();
    do_reset("long_rst");
    wlog.delete();
    send_line(0, XR + 5, 1'b1, 0, 1'b1);
    n_checks++;
    if (wlog.size() != XR) begin n_err++; $display("FAIL long_writes: got %0d want %0d", wlog.size(), XR); end
    n_checks++;
    if (line_err !== 1'b1) begin n_err++; $display("FAIL long_line_err: got %b want 1", line_err); end
    send_line(1, 5, 1'b0, 0, 1'b1);
    n_checks++;
    if (wlog.size() <= XR || wlog[XR].a != XR) begin
      n_err++;
      $display("FAIL long_next_addr: got %0d want %0d", (wlog.size() > XR) ? wlog[XR].a : -1, XR);
    end
    push(1'b1, 1'b0, 8'($urandom), 0);
    n_checks++;
    if (line_err !== 1'b0) begin n_err++; $display("FAIL long_err_clear: got %b want 0", line_err); end
  endtask

  task automatic test_short_line();
    int touched;
    do_reset("short_rst");
    wlog.delete();
    send_line(0, XR, 1'b1, 2, 1'b1);
    send_line(1, XR, 1'b0, 2, 1'b1);
    send_line(2, 100, 1'b0, 2, 1'b1);
    send_line(3, 10, 1'b0, 2, 1'b1);
    n_checks++;
    if (wlog.size() != 2 * XR + 110) begin n_err++; $display("FAIL short_writes: got %0d want %0d", wlog.size(), 2 * XR + 110); end
    n_checks++;
    if (wlog.size() <= 2 * XR + 100 || wlog[2 * XR + 100].a != 3 * XR) begin
      n_err++;
      $display("FAIL short_next_addr: got %0d want %0d",
               (wlog.size() > 2 * XR + 100) ? wlog[2 * XR + 100].a : -1, 3 * XR);
    end
    touched = 0;
    foreach (wlog[i]) if (wlog[i].a >= 2 * XR + 100 && wlog[i].a < 3 * XR) touched++;
    n_checks++;
    if (touched != 0) begin n_err++; $display("FAIL short_gap_untouched: got %0d writes want 0", touched); end
  endtask

  task automatic test_clk_en();
    int bad;
    do_reset("clken_rst");
    wlog.delete();
    n_bad_en = 0; phase = 0;
    send_line(0, XR, 1'b1, 1, 1'b0);
    send_line(1, XR, 1'b0, 1, 1'b0);
    idle(2);
    n_checks++;
    if (wlog.size() != 2 * XR) begin n_err++; $display("FAIL clken_writes: got %0d want %0d", wlog.size(), 2 * XR); end
    bad = 0;
    foreach (wlog[i]) if (wlog[i].a != i || wlog[i].d != (i & 8'hFF)) bad++;
    n_checks++;
    if (bad != 0) begin n_err++; $display("FAIL clken_sequence: got %0d wrong entries want 0", bad); end
    n_checks++;
    if (n_bad_en != 0) begin n_err++; $display("FAIL clken_wes_disabled: got %0d want 0", n_bad_en); end
  endtask

  task automatic test_mid_sof();
    logic [7:0] d_sof, d_nxt;
    do_reset("midsof_rst");
    for (int r = 0; r < 10; r++) send_line(r, XR, r == 0, 0, 1'b1);
    for (int i = 0; i < 7; i++) push(1'b0, 1'b0, 8'($urandom), 0);
    wlog.delete();
    d_sof = 8'($urandom); d_nxt = 8'($urandom);
    push(1'b1, 1'b0, d_sof, 0);
    push(1'b0, 1'b0, d_nxt, 0);
    n_checks++;
    if (sync_err !== 1'b1) begin n_err++; $display("FAIL midsof_sync_err: got %b want 1", sync_err); end
    n_checks++;
    if (wlog.size() != 2 || wlog[0].a != 0 || wlog[0].d != int'(d_sof) || wlog[1].a != 1 || wlog[1].d != int'(d_nxt)) begin
      n_err++;
      $display("FAIL midsof_writes: got n=%0d first=%0d/%h want n=2 0/%h then 1/%h", wlog.size(),
               (wlog.size() > 0) ? wlog[0].a : -1, (wlog.size() > 0) ? wlog[0].d : 0, d_sof, d_nxt);
    end
  endtask

  task automatic test_sof_eol();
    do_reset("sofeol_rst");
    wlog.delete();
    push(1'b1, 1'b1, 8'($urandom), 0);
    push(1'b0, 1'b0, 8'($urandom), 0);
    push(1'b0, 1'b1, 8'($urandom), 0);
    n_checks++;
    if (wlog.size() != 3 || wlog[0].a != 0 || wlog[1].a != XR || wlog[2].a != XR + 1) begin
      n_err++;
      $display("FAIL sofeol_addrs: got n=%0d a1=%0d want 0,%0d,%0d", wlog.size(),
               (wlog.size() > 1) ? wlog[1].a : -1, XR, XR + 1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset("rstmid_pre");
    for (int r = 0; r < 12; r++) send_line(r, XR, r == 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'($urandom), 0);
    do_reset("rstmid_pulse");
    wlog.delete();
    for (int i = 0; i < 20; i++) push(1'b0, i == 9, 8'($urandom), 2);
    n_checks++;
    if (wlog.size() != 0) begin n_err++; $display("FAIL rstmid_no_sof_writes: got %0d want 0", wlog.size()); end
    push(1'b1, 1'b0, 8'($urandom), 0);
    push(1'b0, 1'b0, 8'($urandom), 0);
    n_checks++;
    if (wlog.size() != 2 || wlog[0].a != 0 || wlog[1].a != 1) begin
      n_err++;
      $display("FAIL rstmid_restart: got n=%0d first=%0d want n=2 addrs 0,1", wlog.size(),
               (wlog.size() > 0) ? wlog[0].a : -1);
    end
    n_checks++;
    if (sync_err !== 1'b0) begin n_err++; $display("FAIL rstmid_sync_err: got %b want 0", sync_err); end
  endtask

  initial begin
    n_err = 0; n_checks = 0; phase = 0;
    n_wes = 0; n_fd = 0; last_addr = -1; max_addr = 0; n_bad_en = 0;
    model_reset();
    test_reset();
    test_full_frame();
    test_long_line();
    test_short_line();
    test_clk_en();
    test_mid_sof();
    test_sof_eol();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 Parameter XRES, 640, pixels per line.
REQ-002 Parameter YRES, 480, lines per frame.
REQ-003 Parameter ADDR_WIDTH, 19, frame-buffer address width.
REQ-004 Parameter DATA_WIDTH, 8, pixel width (RGB332).
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clk_en  input  1  pixel-rate enable; logic advances only when high.
REQ-008 pix_data  input  DATA_WIDTH  incoming pixel.
REQ-009 pix_valid  input  1  pix_data valid.
REQ-010 pix_sof  input  1  beat is first pixel of frame (x=0, y=0).
REQ-011 pix_eol  input  1  beat is last pixel of its line.
REQ-012 pix_ready  output  1  writer accepts beat this cycle.
REQ-013 WES  output  1  block-RAM write strobe, active-high.
REQ-014 dout  output  DATA_WIDTH  block-RAM write data (registered).
REQ-015 addr  output  ADDR_WIDTH  block-RAM write address (registered).
REQ-016 frame_done  output  1  one-cycle pulse after the last line is written.
REQ-017 line_err  output  1  sticky: pixel beyond XRES dropped; cleared on accepted SOF.
REQ-018 sync_err  output  1  sticky: SOF received mid-frame; cleared by reset only.

Function
REQ-019 Accept = pix_valid & pix_ready & clk_en; only accepted beats have effect.
REQ-020 pix_ready = clk_en when state is IDLE or WRITE; 0 in DONE.
REQ-021 States: IDLE (discard non-SOF beats), WRITE, DONE.
REQ-022 IDLE->WRITE on an accepted beat with pix_sof=1; that beat writes address 0.
REQ-023 In WRITE: addr = row_base + x; row_base advances by XRES per line via an adder; no multiplier.
REQ-024 Write latency 1 cycle: accepted beat at edge N -> WES=1, dout=pix_data, addr valid after edge N; WES=0 in every other cycle.
REQ-025 x increments per accepted beat; at x=XRES-1 without EOL, further beats on that line are dropped (no WES) and line_err is set.
REQ-026 Accepted EOL: x<=0, row_base<=row_base+XRES, y<=y+1; a short line leaves the remainder of its row unwritten.
REQ-027 EOL on line y=YRES-1 -> DONE; frame_done=1 for exactly the following cycle; DONE->IDLE the next cycle.
REQ-028 SOF accepted in WRITE: sync_err set; beat is written to address 0; x, y, row_base restart from 0.
REQ-029 SOF and EOL on the same beat: treated as SOF, then EOL (1-pixel line 0; next line y=1).
REQ-030 clk_en low: no state, counter or output change except WES forced 0.
REQ-031 Maximum address XRES*YRES-1 = 307199; never exceeded.

Reset
REQ-032 rst low asynchronously forces IDLE, x=y=row_base=0, WES=0, dout=0, addr=0, pix_ready=0, frame_done=0, line_err=0, sync_err=0.
REQ-033 Reset mid-frame abandons the frame; the first write after release requires a new SOF.
REQ-034 Reset release is synchronised: deassertion reaches flops through a 2-flop synchroniser.

Structure
REQ-035 The shared display package holds XRES, YRES, ADDR_WIDTH, DATA_WIDTH and the writer state encoding.
REQ-036 A single sub-module, fb_addr_gen (x, y, row_base counters plus address adder), is natural; the FSM and write-port registers stay in the top.

Verification
REQ-037 Full frame: SOF, then 640 beats per line with EOL, 480 lines, pix_data=addr[7:0] -> 307200 WES pulses, last addr=307199, frame_done one cycle, no errors.
REQ-038 Long line: 645 beats before EOL on line 0 -> 640 writes, line_err=1, line 1 starts at addr 640.
REQ-039 Short line: EOL at beat 100 of line 2 -> next write at addr 1920; addrs 1380-1919 untouched.
REQ-040 Mid-frame SOF at y=10 -> sync_err=1, that beat written at addr 0, next beat at addr 1.
REQ-041 clk_en toggled 1-in-3 across 2 lines -> write sequence identical to continuous enable; WES only on enabled cycles.
REQ-042 rst pulsed low at y=200 -> all outputs 0 immediately; non-SOF beats after release produce no WES.
